// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and ISA constants for the multicycle RISC control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU control decoder: aluop plus R-type funct field to 3-bit ALU control.
module alu_dec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_SUB: alucontrol = ALUC_SUB;
                    FUNCT_AND: alucontrol = ALUC_AND;
                    FUNCT_OR:  alucontrol = ALUC_OR;
                    FUNCT_SLT: alucontrol = ALUC_SLT;
                    default:   alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle datapath: sequencing, enables and mux selects.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [1:0] aluop;
    logic       pcwrite, branch;
    logic       irwrite_raw, regwrite_raw, memwrite_raw;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = S_FETCH;
        aluop        = ALUOP_ADD;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        illegal      = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are masked while reset is high so no datapath state moves during reset.
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign irwrite  = ~reset & irwrite_raw;
    assign regwrite = ~reset & regwrite_raw;
    assign memwrite = ~reset & memwrite_raw;

    alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: directed plus random instruction streams against a per-instruction model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } vec_t;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .iord       (iord),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    function automatic int n_cycles(input logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs at cycle s of an instruction (s=0 is its fetch).
    function automatic vec_t model(input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input int s);
        vec_t v;
        v = '0;
        v.alucontrol = 3'b010;
        if (s == 0) begin
            v.irwrite = 1'b1; v.pcen = 1'b1; v.alusrcb = 2'b01;
        end else if (s == 1) begin
            v.alusrcb = 2'b11;
            v.illegal = (n_cycles(o) == 2);
        end else begin
            case (o)
                6'b100011, 6'b101011: begin
                    if (s == 2) begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
                    else if (o == 6'b101011) begin v.iord = 1'b1; v.memwrite = 1'b1; end
                    else if (s == 3) v.iord = 1'b1;
                    else begin v.memtoreg = 1'b1; v.regwrite = 1'b1; end
                end
                6'b000000: begin
                    if (s == 2) begin v.alusrca = 1'b1; v.alucontrol = rtype_alu(f); end
                    else begin v.regdst = 1'b1; v.regwrite = 1'b1; end
                end
                6'b000100: begin
                    v.alusrca = 1'b1; v.alucontrol = 3'b110; v.pcsrc = 2'b01; v.pcen = z;
                end
                6'b001000: begin
                    if (s == 2) begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
                    else v.regwrite = 1'b1;
                end
                default: begin
                    v.pcsrc = 2'b10; v.pcen = 1'b1;
                end
            endcase
        end
        return v;
    endfunction

    task automatic check(input string tag, input vec_t exp);
        vec_t act;
        act = {pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, illegal};
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_en_off(input string tag);
        checks++;
        assert ({pcen, irwrite, regwrite, memwrite} === 4'b0000) else begin
            errors++;
            $error("FAIL %s: observed enables %b expected 0000", tag,
                   {pcen, irwrite, regwrite, memwrite});
        end
    endtask

    // zmode: 0/1 force zero, 2 random. rst_at: cycle index at which reset is raised (-1 = never).
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int rst_at);
        int   n;
        vec_t e;
        n = n_cycles(o);
        for (int s = 0; s < n; s++) begin
            if (rst_at < 0 || s <= rst_at) begin
                @(posedge clk);
                #1;
                reset = (s == rst_at);
                if (s == 0) begin
                    op = 6'($urandom); funct = 6'($urandom);
                end else begin
                    op = o; funct = f;
                end
                zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
                @(negedge clk);
                e = model(o, f, zero, s);
                if (s == rst_at) begin
                    e.pcen = 1'b0; e.irwrite = 1'b0; e.regwrite = 1'b0; e.memwrite = 1'b0;
                end
                check($sformatf("%s/c%0d", tag, s), e);
            end
        end
    endtask

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] functs [5];
        logic [5:0] ro, rf;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        functs    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset = 1'b1;
        op    = 6'b100011;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            zero = 1'b1;
            @(negedge clk);
            check_en_off($sformatf("reset_hold%0d", i));
        end

        run_instr("lw", 6'b100011, 6'b000000, 2, -1);
        run_instr("rtype_sub", 6'b000000, 6'b100010, 2, -1);
        run_instr("rtype_slt", 6'b000000, 6'b101010, 2, -1);
        run_instr("rtype_and", 6'b000000, 6'b100100, 2, -1);
        run_instr("rtype_or", 6'b000000, 6'b100101, 2, -1);
        run_instr("rtype_badf", 6'b000000, 6'b111111, 2, -1);
        run_instr("beq_taken", 6'b000100, 6'b000000, 1, -1);
        run_instr("beq_not", 6'b000100, 6'b000000, 0, -1);
        run_instr("illegal", 6'b111111, 6'b000000, 2, -1);
        run_instr("sw", 6'b101011, 6'b000000, 2, -1);
        run_instr("addi", 6'b001000, 6'b000000, 2, -1);
        run_instr("j", 6'b000010, 6'b000000, 2, -1);
        run_instr("sw_rst", 6'b101011, 6'b000000, 2, 3);
        run_instr("after_rst", 6'b100011, 6'b000000, 2, -1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) ro = 6'($urandom);
            else ro = legal_ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) rf = 6'($urandom);
            else rf = functs[$urandom_range(0, 4)];
            if ($urandom_range(0, 39) == 0)
                run_instr($sformatf("rnd%0d_rst", i), ro, rf, 2, $urandom_range(0, n_cycles(ro) - 1));
            else
                run_instr($sformatf("rnd%0d", i), ro, rf, 2, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
